// File: rtl/vga_cvi_pkg.sv
// vga_cvi_pkg: shared FSM states, XGA timing constants and FIFO entry sizing for the CVI capture path
package vga_cvi_pkg;
  typedef enum logic [1:0] {SEEK, ARMED, ACTIVE, DROP} cvi_state_t;
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_V_ACTIVE = 768;
  function automatic int entry_w(input int data_w);
    return data_w + 2;
  endfunction
endpackage

// File: rtl/vga_cvi_fifo.sv
// vga_cvi_fifo: synchronous first-word-fall-through FIFO with full/empty flags
// ports: clk, reset (sync, active-high); wr_en/wr_data push; rd_en pops the entry shown on rd_data;
// full/empty flags. A write while full is accepted when a read happens in the same cycle.
module vga_cvi_fifo #(
  parameter int W = 26,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_wr, do_rd;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign rd_data = mem_q[rp_q];
  always_comb begin
    do_rd = rd_en & ~empty;
    do_wr = wr_en & (~full | do_rd);
    wp_d = wp_q + AW'(do_wr);
    rp_d = rp_q + AW'(do_rd);
    cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= wr_data;
  end
endmodule

// File: rtl/vga_cvi_capture.sv
// vga_cvi_capture: clocked-video input to Avalon-ST pixel stream with sop/eop framing and FIFO backpressure
// ports: clk, reset (sync, active-high); capture_en arms capture on the next vsync edge;
// vid_data/vid_datavalid/vid_h_sync/vid_v_sync parallel video in; dout_* stream out with ready;
// status_clr clears sticky overflow; frame_err pulses on a short frame; frame_cnt counts completed
// frames; meas_width/meas_height report measured geometry when VGA_CVI_MEASURE_EN is defined (else 0).
module vga_cvi_capture import vga_cvi_pkg::*; #(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int DATA_W = 24,
  parameter int FIFO_DEPTH = 16,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_h_sync,
  input  logic              vid_v_sync,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_sop,
  output logic              dout_eop,
  input  logic              status_clr,
  output logic              overflow,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       meas_width,
  output logic [15:0]       meas_height
);
  localparam int PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int PIX_W = PIXELS < 2 ? 1 : $clog2(PIXELS);
  localparam logic [PIX_W-1:0] LAST = PIX_W'(PIXELS - 1);
  localparam int EW = entry_w(DATA_W);
  logic [DATA_W-1:0] data_q, data_d;
  logic dv_q, dv_d, vs_q, vs_d, vs_prev_q, vs_prev_d, vs_edge;
  cvi_state_t state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic ovf_q, ovf_d, ovf_set, ferr_q, ferr_d;
  logic wr_en, wr_sop, wr_eop, can_wr, fifo_full, fifo_empty;
  logic [EW-1:0] rd_entry;
  vga_cvi_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data({wr_eop, wr_sop, data_q}),
    .rd_en(dout_ready),
    .rd_data(rd_entry),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign dout_valid = ~fifo_empty;
  assign dout_data = rd_entry[DATA_W-1:0];
  assign dout_sop = dout_valid & rd_entry[DATA_W];
  assign dout_eop = dout_valid & rd_entry[DATA_W+1];
  assign overflow = ovf_q;
  assign frame_err = ferr_q;
  assign frame_cnt = fcnt_q;
  // syncs are stored as "asserted" so reset leaves them deasserted and cannot fake an edge
  assign vs_edge = vs_q & ~vs_prev_q;
  // a full FIFO still accepts a write when the head is being popped this cycle
  assign can_wr = ~fifo_full | dout_ready;
  always_comb begin
    data_d = vid_data;
    dv_d = vid_datavalid;
    vs_d = vid_v_sync ^ SYNC_ACTIVE_LOW;
    vs_prev_d = vs_q;
    state_d = state_q;
    pix_d = pix_q;
    fcnt_d = fcnt_q;
    ovf_set = 1'b0;
    ferr_d = 1'b0;
    wr_en = 1'b0;
    wr_sop = 1'b0;
    wr_eop = 1'b0;
    unique case (state_q)
      SEEK: if (vs_edge && capture_en) begin
        state_d = ARMED;
        pix_d = '0;
      end
      ARMED, ACTIVE: if (vs_edge) begin
        ferr_d = state_q == ACTIVE;
        pix_d = '0;
        state_d = ARMED;
      end else if (dv_q) begin
        if (!can_wr) begin
          ovf_set = 1'b1;
          state_d = DROP;
        end else begin
          wr_en = 1'b1;
          wr_sop = state_q == ARMED;
          wr_eop = pix_q == LAST;
          pix_d = wr_eop ? '0 : pix_q + 1'b1;
          fcnt_d = fcnt_q + 16'(wr_eop);
          state_d = wr_eop ? SEEK : ACTIVE;
        end
      end
      DROP: if (vs_edge) begin
        state_d = ARMED;
        pix_d = '0;
      end
      default: state_d = SEEK;
    endcase
    ovf_d = ovf_set | (ovf_q & ~status_clr);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      dv_q <= 1'b0;
      vs_q <= 1'b0;
      vs_prev_q <= 1'b0;
      state_q <= SEEK;
      pix_q <= '0;
      fcnt_q <= '0;
      ovf_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      data_q <= data_d;
      dv_q <= dv_d;
      vs_q <= vs_d;
      vs_prev_q <= vs_prev_d;
      state_q <= state_d;
      pix_q <= pix_d;
      fcnt_q <= fcnt_d;
      ovf_q <= ovf_d;
      ferr_q <= ferr_d;
    end
  end
`ifdef VGA_CVI_MEASURE_EN
  logic hs_q, hs_d, hs_prev_q, hs_prev_d, hs_edge, line_nz;
  logic [15:0] line_q, line_d, lines_q, lines_d, lines_eff, mw_q, mw_d, mh_q, mh_d;
  assign meas_width = mw_q;
  assign meas_height = mh_q;
  always_comb begin
    hs_d = vid_h_sync ^ SYNC_ACTIVE_LOW;
    hs_prev_d = hs_q;
    hs_edge = hs_q & ~hs_prev_q;
    line_nz = line_q != '0;
    // a line closed by the hsync edge in the same cycle as vsync still belongs to the ending frame
    lines_eff = lines_q + 16'(hs_edge & line_nz);
    line_d = hs_edge ? 16'(dv_q) : line_q + 16'(dv_q);
    mw_d = hs_edge && line_nz ? line_q : mw_q;
    lines_d = vs_edge ? '0 : lines_eff;
    mh_d = vs_edge ? lines_eff : mh_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q <= 1'b0;
      hs_prev_q <= 1'b0;
      line_q <= '0;
      lines_q <= '0;
      mw_q <= '0;
      mh_q <= '0;
    end else begin
      hs_q <= hs_d;
      hs_prev_q <= hs_prev_d;
      line_q <= line_d;
      lines_q <= lines_d;
      mw_q <= mw_d;
      mh_q <= mh_d;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = vid_h_sync;
  assign meas_width = '0;
  assign meas_height = '0;
`endif
endmodule
